pipe_stage_chain: RTL and testbench

//  Parametrised N-stage control/data pipeline carrying valid, control bus, Rd, a data lane and an aux lane.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_stage.sv | 67 ++++++
 rtl/pipe_stage_chain.sv | 112 +++++++++++
 tb/tb_pipe_stage_chain.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the decode-to-writeback pipeline: control bus bit
// positions, default widths and the control bus type.
package pipe_pkg;

    localparam int unsigned CTRL_W_DEF = 8;
    localparam int unsigned RD_W_DEF   = 5;

    // Control bus bit positions
    localparam int unsigned MEM2REG  = 7;
    localparam int unsigned REGWRITE = 6;
    localparam int unsigned MEMWRITE = 5;
    localparam int unsigned MEMREAD  = 4;
    localparam int unsigned XFERBYTE = 3;
    localparam int unsigned ALUOP_HI = 2;
    localparam int unsigned ALUOP_LO = 0;

    typedef logic [CTRL_W_DEF-1:0] ctrl_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage register carrying valid, control, Rd, data and aux.
// Priority at each edge: flush > hold > bubble > advance. A killed entry
// (flush or bubble) clears only valid and control; the payload fields are
// left alone so nothing downstream sees a stray RegWrite/MemWrite.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned RD_W   = RD_W_DEF,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_flush,
    input  logic              i_hold,
    input  logic              i_bubble,
    input  logic              i_valid,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [RD_W-1:0]   i_rd,
    input  logic [DATA_W-1:0] i_data,
    input  logic [DATA_W-1:0] i_aux,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [RD_W-1:0]   o_rd,
    output logic [DATA_W-1:0] o_data,
    output logic [DATA_W-1:0] o_aux
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [RD_W-1:0]   r_rd;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_aux;

    // Stage register: flush, hold, bubble or advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rd    <= '0;
            r_data  <= '0;
            r_aux   <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (i_hold) begin
            r_valid <= r_valid;
        end else if (i_bubble) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else begin
            // Control is zeroed for an invalid entry so valid=0 always implies ctrl=0
            r_valid <= i_valid;
            r_ctrl  <= i_valid ? i_ctrl : '0;
            r_rd    <= i_rd;
            r_data  <= i_data;
            r_aux   <= i_aux;
        end
    end

    assign o_valid = r_valid;
    assign o_ctrl  = r_ctrl;
    assign o_rd    = r_rd;
    assign o_data  = r_data;
    assign o_aux   = r_aux;

endmodule

// File: rtl/pipe_stage_chain.sv
// N-stage control/data pipeline between decode and writeback with per-stage
// stall, flush, bubble insertion, data-lane injection and a retire counter.
// A stall on any stage freezes every stage upstream of it.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int unsigned       STAGES = 3,
    parameter int unsigned       DATA_W = 64,
    parameter int unsigned       CTRL_W = CTRL_W_DEF,
    parameter int unsigned       RD_W   = RD_W_DEF,
    parameter logic [STAGES-1:0] INJECT = 3'b110,
    parameter int unsigned       CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [DATA_W-1:0]        in_aux,
    output logic                     in_ready,
    input  logic [STAGES*DATA_W-1:0] stg_data_in,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        stg_valid,
    output logic [STAGES*CTRL_W-1:0] stg_ctrl,
    output logic [STAGES*RD_W-1:0]   stg_rd,
    output logic [STAGES*DATA_W-1:0] stg_data,
    output logic [STAGES*DATA_W-1:0] stg_aux,
    output logic [CNT_W-1:0]         retire_cnt
);

    logic [STAGES-1:0]             w_hold;
    logic [STAGES-1:0]             w_bubble;
    logic [STAGES-1:0]             w_valid;
    logic [STAGES-1:0][CTRL_W-1:0] w_ctrl;
    logic [STAGES-1:0][RD_W-1:0]   w_rd;
    logic [STAGES-1:0][DATA_W-1:0] w_data;
    logic [STAGES-1:0][DATA_W-1:0] w_aux;
    logic [STAGES-1:0]             w_in_valid;
    logic [STAGES-1:0][CTRL_W-1:0] w_in_ctrl;
    logic [STAGES-1:0][RD_W-1:0]   w_in_rd;
    logic [STAGES-1:0][DATA_W-1:0] w_in_data;
    logic [STAGES-1:0][DATA_W-1:0] w_in_aux;
    logic [CNT_W-1:0]              r_retire_cnt;
    // Slices whose INJECT bit is clear (and slice 0) never reach a stage
    logic                          w_unused_inj;

    assign w_unused_inj = ^stg_data_in;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // hold[k] is the OR of this stall and every downstream stall
        assign w_hold[k] = |stall[STAGES-1:k];

        if (k == 0) begin : g_head
            assign w_bubble[k]   = 1'b0;
            assign w_in_valid[k] = in_valid;
            assign w_in_ctrl[k]  = in_ctrl;
            assign w_in_rd[k]    = in_rd;
            assign w_in_data[k]  = in_data;
            assign w_in_aux[k]   = in_aux;
        end else begin : g_body
            // Upstream frozen while this stage moves on: insert a bubble
            assign w_bubble[k]   = w_hold[k-1] & ~w_hold[k];
            assign w_in_valid[k] = w_valid[k-1];
            assign w_in_ctrl[k]  = w_ctrl[k-1];
            assign w_in_rd[k]    = w_rd[k-1];
            assign w_in_data[k]  = INJECT[k] ? stg_data_in[k*DATA_W +: DATA_W] : w_data[k-1];
            assign w_in_aux[k]   = w_aux[k-1];
        end

        pipe_stage #(
            .CTRL_W (CTRL_W),
            .RD_W   (RD_W),
            .DATA_W (DATA_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .i_flush  (flush[k]),
            .i_hold   (w_hold[k]),
            .i_bubble (w_bubble[k]),
            .i_valid  (w_in_valid[k]),
            .i_ctrl   (w_in_ctrl[k]),
            .i_rd     (w_in_rd[k]),
            .i_data   (w_in_data[k]),
            .i_aux    (w_in_aux[k]),
            .o_valid  (w_valid[k]),
            .o_ctrl   (w_ctrl[k]),
            .o_rd     (w_rd[k]),
            .o_data   (w_data[k]),
            .o_aux    (w_aux[k])
        );
    end

    // Count valid entries leaving the last stage; wraps at 2^CNT_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retire_cnt <= '0;
        end else if (w_valid[STAGES-1] && !w_hold[STAGES-1]) begin
            r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = ~w_hold[0];
    assign stg_valid  = w_valid;
    assign stg_ctrl   = w_ctrl;
    assign stg_rd     = w_rd;
    assign stg_data   = w_data;
    assign stg_aux    = w_aux;
    assign retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: a table of per-cycle vectors for streaming and
// stall behaviour, hand sequences for flush, async reset and counter wrap,
// and a scoreboard of entries expected to retire from the last stage.
module tb_pipe_stage_chain;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int RW = 5;
    localparam logic [63:0] ONES = '1;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [CW-1:0]   in_ctrl;
    logic [RW-1:0]   in_rd;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   in_aux;
    logic [3*DW-1:0] stg_data_in;
    logic [2:0]      stall;
    logic [2:0]      flush;

    logic            in_ready,  in_ready4;
    logic [2:0]      stg_valid, stg_valid4;
    logic [3*CW-1:0] stg_ctrl,  stg_ctrl4;
    logic [3*RW-1:0] stg_rd,    stg_rd4;
    logic [3*DW-1:0] stg_data,  stg_data4;
    logic [3*DW-1:0] stg_aux,   stg_aux4;
    logic [31:0]     retire_cnt;
    logic [3:0]      retire_cnt4;

    always #5 clk = ~clk;

    pipe_stage_chain #(
        .STAGES (3), .DATA_W (DW), .CTRL_W (CW), .RD_W (RW),
        .INJECT (3'b110), .CNT_W (32)
    ) u_dut (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ctrl (in_ctrl),
        .in_rd (in_rd), .in_data (in_data), .in_aux (in_aux), .in_ready (in_ready),
        .stg_data_in (stg_data_in), .stall (stall), .flush (flush),
        .stg_valid (stg_valid), .stg_ctrl (stg_ctrl), .stg_rd (stg_rd),
        .stg_data (stg_data), .stg_aux (stg_aux), .retire_cnt (retire_cnt)
    );

    pipe_stage_chain #(
        .STAGES (3), .DATA_W (DW), .CTRL_W (CW), .RD_W (RW),
        .INJECT (3'b110), .CNT_W (4)
    ) u_dut4 (
        .clk (clk), .reset (reset), .in_valid (in_valid), .in_ctrl (in_ctrl),
        .in_rd (in_rd), .in_data (in_data), .in_aux (in_aux), .in_ready (in_ready4),
        .stg_data_in (stg_data_in), .stall (stall), .flush (flush),
        .stg_valid (stg_valid4), .stg_ctrl (stg_ctrl4), .stg_rd (stg_rd4),
        .stg_data (stg_data4), .stg_aux (stg_aux4), .retire_cnt (retire_cnt4)
    );

    typedef struct {
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [DW-1:0] aux;
    } ent_t;

    typedef struct {
        logic          vld;
        logic [CW-1:0] ctrl;
        logic [RW-1:0] rd;
        logic [DW-1:0] data;
        logic [DW-1:0] aux;
        logic [2:0]    stall;
        logic [2:0]    flush;
        logic          exp_ready;
        logic [2:0]    exp_valid;
        logic [31:0]   exp_cnt;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    ent_t        sb[$];
    int unsigned sb_cnt;
    vec_t        vt[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [CW-1:0] c, input logic [RW-1:0] r,
                         input logic [DW-1:0] d, input logic [DW-1:0] a,
                         input logic [2:0] s, input logic [2:0] f);
        in_valid = v; in_ctrl = c; in_rd = r; in_data = d; in_aux = a;
        stall = s; flush = f;
    endtask

    // Scoreboard step, run on the falling edge with the inputs for the next rising edge
    task automatic mon();
        ent_t e;
        if (reset !== 1'b1) return;
        chk("retire_cnt", retire_cnt, 64'(sb_cnt));
        chk("retire_cnt4", retire_cnt4, 64'(sb_cnt % 16));
        if (stg_valid[2] && !stall[2]) begin
            if (sb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_retire: got rd %0d expected none", stg_rd[2*RW +: RW]);
            end else begin
                e = sb.pop_front();
                chk("ret_ctrl", stg_ctrl[2*CW +: CW], e.ctrl);
                chk("ret_rd",   stg_rd[2*RW +: RW],   e.rd);
                chk("ret_data", stg_data[2*DW +: DW], e.data);
                chk("ret_aux",  stg_aux[2*DW +: DW],  e.aux);
            end
            sb_cnt++;
        end
        if (in_valid && stall == 3'b000 && !flush[0])
            sb.push_back('{in_ctrl, in_rd, stg_data_in[2*DW +: DW], in_aux});
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            to_neg();
            to_pos();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        sb_cnt      = 0;
        stg_data_in = {64'h33, 64'h22, 64'h11};
        drive(1'b0, '0, '0, '0, '0, 3'b000, 3'b000);

        //        vld   ctrl   rd     data           aux            stall   flush   rdy   valid   cnt
        vt[0]  = '{1'b1, 8'hFF, 5'd31, ONES,          ONES,          3'b000, 3'b000, 1'b1, 3'b001, 32'd0};
        vt[1]  = '{1'b1, 8'hFF, 5'd31, ONES,          ONES,          3'b000, 3'b000, 1'b1, 3'b011, 32'd0};
        vt[2]  = '{1'b1, 8'hFF, 5'd31, ONES,          ONES,          3'b000, 3'b000, 1'b1, 3'b111, 32'd0};
        vt[3]  = '{1'b1, 8'h5A, 5'd7,  64'h0123,      64'h5555,      3'b000, 3'b000, 1'b1, 3'b111, 32'd1};
        vt[4]  = '{1'b1, 8'hC3, 5'd8,  64'h0456,      64'h6666,      3'b010, 3'b000, 1'b0, 3'b011, 32'd2};
        vt[5]  = '{1'b1, 8'hC3, 5'd8,  64'h0456,      64'h6666,      3'b010, 3'b000, 1'b0, 3'b011, 32'd2};
        vt[6]  = '{1'b1, 8'h3C, 5'd12, 64'h0789,      64'hABCD,      3'b000, 3'b000, 1'b1, 3'b111, 32'd2};
        vt[7]  = '{1'b0, 8'h00, 5'd0,  64'h0,         64'h0,         3'b000, 3'b000, 1'b1, 3'b110, 32'd3};
        vt[8]  = '{1'b0, 8'h00, 5'd0,  64'h0,         64'h0,         3'b000, 3'b000, 1'b1, 3'b100, 32'd4};
        vt[9]  = '{1'b0, 8'h00, 5'd0,  64'h0,         64'h0,         3'b000, 3'b000, 1'b1, 3'b000, 32'd5};
        vt[10] = '{1'b0, 8'h00, 5'd0,  64'h0,         64'h0,         3'b000, 3'b000, 1'b1, 3'b000, 32'd5};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", stg_valid, 0);
        chk("rst_ctrl", stg_ctrl, 0);
        chk("rst_rd", stg_rd, 0);
        chk("rst_data_hi", stg_data[191:128], 0);
        chk("rst_aux_lo", stg_aux[63:0], 0);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_cnt4", retire_cnt4, 0);
        chk("rst_valid4", stg_valid4, 0);
        reset = 1'b1;

        // Streaming and mid-stream stall of stage 1
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].vld, vt[i].ctrl, vt[i].rd, vt[i].data, vt[i].aux, vt[i].stall, vt[i].flush);
            to_neg();
            chk($sformatf("ready[%0d]", i), in_ready, vt[i].exp_ready);
            to_pos();
            chk($sformatf("valid[%0d]", i), stg_valid, vt[i].exp_valid);
            chk($sformatf("cnt[%0d]", i), retire_cnt, vt[i].exp_cnt);
            if (i == 2) begin
                chk("s0_data_no_inject", stg_data[0*DW +: DW], ONES);
                chk("s1_data_inject", stg_data[1*DW +: DW], 64'h22);
                chk("s2_data_inject", stg_data[2*DW +: DW], 64'h33);
                chk("s2_aux", stg_aux[2*DW +: DW], ONES);
                chk("s2_ctrl", stg_ctrl[2*CW +: CW], 8'hFF);
            end
        end

        // Flush of stage 0 kills the incoming entry, payload fields keep old values
        drive(1'b1, 8'hFF, 5'd9, 64'hDEAD, 64'hBEEF, 3'b000, 3'b000);
        cycles(1);
        drive(1'b1, 8'hFF, 5'd10, 64'hF00D, 64'h1, 3'b000, 3'b001);
        cycles(1);
        chk("fl0_valid0", stg_valid[0], 0);
        chk("fl0_ctrl0", stg_ctrl[0*CW +: CW], 0);
        chk("fl0_rd0", stg_rd[0*RW +: RW], 9);
        chk("fl0_data0", stg_data[0*DW +: DW], 64'hDEAD);
        chk("fl0_valid1", stg_valid[1], 1);
        chk("fl0_ctrl1", stg_ctrl[1*CW +: CW], 8'hFF);
        drive(1'b0, '0, '0, '0, '0, 3'b000, 3'b000);
        cycles(3);

        // Flush and stall on stage 1 together: stage 1 killed, stage 0 holds
        drive(1'b1, 8'h44, 5'd3, 64'hA0, 64'hA1, 3'b000, 3'b000);
        cycles(1);
        drive(1'b1, 8'h66, 5'd4, 64'hB0, 64'hB1, 3'b000, 3'b000);
        cycles(1);
        drive(1'b1, 8'h77, 5'd5, 64'hC0, 64'hC1, 3'b010, 3'b010);
        to_neg();
        chk("fs1_ready", in_ready, 0);
        to_pos();
        chk("fs1_valid", stg_valid, 3'b001);
        chk("fs1_ctrl1", stg_ctrl[1*CW +: CW], 0);
        chk("fs1_rd1", stg_rd[1*RW +: RW], 3);
        chk("fs1_ctrl0", stg_ctrl[0*CW +: CW], 8'h66);
        chk("fs1_aux0", stg_aux[0*DW +: DW], 64'hB1);
        void'(sb.pop_front());
        drive(1'b0, '0, '0, '0, '0, 3'b000, 3'b000);
        cycles(4);
        chk("cnt_after_flush", retire_cnt, 7);

        // Asynchronous reset between edges while stalled and flushing
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'h11 * (i + 1)), 5'(20 + i), 64'(i), 64'(i + 100), 3'b000, 3'b000);
            cycles(1);
        end
        chk("pre_rst_valid", stg_valid, 3'b111);
        drive(1'b1, 8'hEE, 5'd1, 64'h1, 64'h1, 3'b100, 3'b001);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", stg_valid, 0);
        chk("arst_ctrl", stg_ctrl, 0);
        chk("arst_rd", stg_rd, 0);
        chk("arst_data_mid", stg_data[127:64], 0);
        chk("arst_aux_hi", stg_aux[191:128], 0);
        chk("arst_cnt", retire_cnt, 0);
        chk("arst_cnt4", retire_cnt4, 0);
        sb.delete();
        sb_cnt = 0;
        to_neg();
        to_pos();
        chk("arst_hold_valid", stg_valid, 0);
        reset = 1'b1;
        drive(1'b0, '0, '0, '0, '0, 3'b000, 3'b000);

        // 17 retirements: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 8'(i + 1), 5'(i), 64'(i * 3), 64'(i * 7), 3'b000, 3'b000);
            cycles(1);
        end
        drive(1'b0, '0, '0, '0, '0, 3'b000, 3'b000);
        cycles(4);
        chk("wrap_cnt4", retire_cnt4, 4'd1);
        chk("wrap_cnt32", retire_cnt, 32'd17);
        chk("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
